// File: rtl/shift_pkg.sv
// Shared constants for shift-register orientation selection.
package shift_pkg;
    localparam int SHIFT_LEFT  = 0;
    localparam int SHIFT_RIGHT = 1;
endpackage

// File: rtl/serial_shift_register.sv
// Serial-in/serial-out shift register with parallel tap; delays a 1-bit
// stream by DEPTH enabled clocks in either shift orientation.
module serial_shift_register
    import shift_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int SHIFT_DIR = SHIFT_LEFT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in,
    output logic             out,
    output logic [DEPTH-1:0] q
);

    if (DEPTH < 1 || (SHIFT_DIR != SHIFT_LEFT && SHIFT_DIR != SHIFT_RIGHT)) begin : g_bad_cfg
        $fatal(1, "serial_shift_register: DEPTH must be >= 1 and SHIFT_DIR 0 or 1");
    end

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;
    logic [DEPTH-1:0] shifted;

    // DEPTH=1 gets its own branch so the slice sr_q[DEPTH-2:0] is never built.
    if (DEPTH == 1) begin : g_single
        always_comb shifted = in;
    end else if (SHIFT_DIR == SHIFT_LEFT) begin : g_left
        always_comb shifted = {sr_q[DEPTH-2:0], in};
    end else begin : g_right
        always_comb shifted = {in, sr_q[DEPTH-1:1]};
    end

    always_comb begin
        sr_d = sr_q;
        if (enable) sr_d = shifted;
    end

    always_ff @(posedge clk) begin
        if (reset) sr_q <= '0;
        else       sr_q <= sr_d;
    end

    // The last stage sits at the opposite end from the entry point.
    if (SHIFT_DIR == SHIFT_LEFT) begin : g_out_left
        assign out = sr_q[DEPTH-1];
    end else begin : g_out_right
        assign out = sr_q[0];
    end

    assign q = sr_q;

endmodule

// File: tb/tb_serial_shift_register.sv
// Scoreboard bench: left/right DEPTH=8 and left DEPTH=1 instances share stimulus.
module tb_serial_shift_register;
    import shift_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       din = 1'b0;
    logic       out_l, out_r, out_1;
    logic [7:0] q_l, q_r;
    logic [0:0] q_1;

    int n_chk  = 0;
    int n_fail = 0;

    logic exp8[$];
    logic exp1[$];
    logic hist[$];
    logic last8, last1;

    always #5 clk = ~clk;

    serial_shift_register #(.DEPTH(8), .SHIFT_DIR(SHIFT_LEFT)) u_left (
        .clk(clk), .reset(reset), .enable(enable), .in(din), .out(out_l), .q(q_l));
    serial_shift_register #(.DEPTH(8), .SHIFT_DIR(SHIFT_RIGHT)) u_right (
        .clk(clk), .reset(reset), .enable(enable), .in(din), .out(out_r), .q(q_r));
    serial_shift_register #(.DEPTH(1), .SHIFT_DIR(SHIFT_LEFT)) u_one (
        .clk(clk), .reset(reset), .enable(enable), .in(din), .out(out_1), .q(q_1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp8 = {};
        repeat (7) exp8.push_back(1'b0);
        exp1 = {};
        hist = {};
        repeat (8) hist.push_back(1'b0);
        last8 = 1'b0;
        last1 = 1'b0;
    endtask

    // One clock: drive mid-cycle, update the scoreboard, compare after the edge.
    task automatic step(input logic r, input logic en, input logic d);
        logic [7:0] ql, qr;
        @(negedge clk);
        reset  = r;
        enable = en;
        din    = d;
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else if (en) begin
            exp8.push_back(d);
            last8 = exp8.pop_front();
            exp1.push_back(d);
            last1 = exp1.pop_front();
            hist.push_back(d);
            hist.delete(0);
        end
        for (int i = 0; i < 8; i++) begin
            ql[i] = hist[7-i];
            qr[i] = hist[i];
        end
        chk("out_left",  {31'd0, out_l}, {31'd0, last8});
        chk("out_right", {31'd0, out_r}, {31'd0, last8});
        chk("q_left",    {24'd0, q_l},   {24'd0, ql});
        chk("q_right",   {24'd0, q_r},   {24'd0, qr});
        chk("out_d1",    {31'd0, out_1}, {31'd0, last1});
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] seen;
        logic [7:0] a5;
        logic [7:0] q_before;
        logic       o_before;

        model_reset();

        // 1. reset with enable high
        step(1'b1, 1'b1, 1'b1);
        chk("reset_q_left",  {24'd0, q_l}, 32'h0);
        chk("reset_q_right", {24'd0, q_r}, 32'h0);

        // 2/3. pattern latency and parallel tap
        pat = 8'b10010101;
        seen = '0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, pat[7-i]);
            if (i < 7) chk("fill_out_zero", {31'd0, out_l}, 32'd0);
        end
        seen[7] = out_l;
        chk("tap_left",  {24'd0, q_l}, 32'b10010101);
        chk("tap_right", {24'd0, q_r}, 32'b10101001);
        for (int i = 1; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0);
            seen[7-i] = out_l;
        end
        chk("pattern_out_seq", {24'd0, seen}, {24'd0, pat});

        // 4. hold: load A5, then freeze with toggling input
        a5 = 8'hA5;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, a5[7-i]);
        chk("load_a5", {24'd0, q_l}, 32'hA5);
        q_before = q_l;
        o_before = out_l;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, i[0]);
        chk("hold_q",   {24'd0, q_l},   {24'd0, q_before});
        chk("hold_out", {31'd0, out_l}, {31'd0, o_before});
        seen = '0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0);
            seen[7-i] = out_l;
        end
        // The first re-enabled edge pops the bit just behind the MSB of A5.
        chk("resume_seq", {24'd0, seen}, {24'd0, {a5[6:0], 1'b0}});

        // 5. reset mid-stream with register full of ones
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1);
        chk("full_ones", {24'd0, q_l}, 32'hFF);
        step(1'b1, 1'b1, 1'b1);
        chk("midreset_q",   {24'd0, q_r}, 32'h0);
        chk("midreset_out", {31'd0, out_l}, 32'd0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("post_reset_out", {31'd0, out_r}, 32'd0);
        end

        // 6. DEPTH=1 delay
        step(1'b0, 1'b1, 1'b1);
        chk("d1_bit0", {31'd0, out_1}, 32'd1);
        step(1'b0, 1'b1, 1'b0);
        chk("d1_bit1", {31'd0, out_1}, 32'd0);
        step(1'b0, 1'b1, 1'b1);
        chk("d1_bit2", {31'd0, out_1}, 32'd1);

        // random tail through the scoreboard
        for (int i = 0; i < 60; i++)
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
